alien_march_ctrl: RTL

Sequencer for the enemy formation. Owns the formation origin, march direction and step cadence; advances the formation by ENEMY_SPEED per step, drops by DROP and reverses at the playfield edges, speeds up as enemies die, and flags landing (game over) and wave clear. It sits between the frame-timing logic and the enemy renderer and alive-tracker, and its flags feed the game-state logic.

---
 rtl/alien_march_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alien_march_ctrl.sv
// Enemy formation sequencer: owns origin, direction and step cadence; marches, drops and
// reverses at the playfield edges, speeds up as enemies die, flags landing and wave clear.
module alien_march_ctrl #(
    parameter int HRES         = 1280,
    parameter int VRES         = 720,
    parameter int COLS         = 8,
    parameter int ROWS         = 4,
    parameter int ENEMY_W      = 32,
    parameter int ENEMY_H      = 28,
    parameter int SPACING_X    = 10,
    parameter int SPACING_Y    = 16,
    parameter int ENEMY_SPEED  = 2,
    parameter int DROP         = 32,
    parameter int START_X      = 64,
    parameter int START_Y      = 140,
    parameter int LAND_Y       = 700,
    parameter int PERIOD_SHIFT = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            frame,
    input  logic                            run,
    input  logic                            restart,
    input  logic                            any_alive,
    input  logic [$clog2(ROWS*COLS+1)-1:0]  alive_cnt,
    input  logic [$clog2(COLS)-1:0]         col_lo,
    input  logic [$clog2(COLS)-1:0]         col_hi,
    input  logic [$clog2(ROWS)-1:0]         row_hi,
    output logic signed [11:0]              form_x,
    output logic [9:0]                      form_y,
    output logic                            dir,
    output logic                            step,
    output logic                            landed,
    output logic                            wave_clear
);

    localparam int CW      = $clog2(ROWS*COLS+1);
    localparam int PITCH_X = ENEMY_W + SPACING_X;
    localparam int PITCH_Y = ENEMY_H + SPACING_Y;

    typedef enum logic [1:0] {StIdle, StMarch, StLanded, StClear} state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            fcnt_q, fcnt_d;
    logic signed [11:0]       form_x_q, form_x_d;
    logic [9:0]               form_y_q, form_y_d;
    logic                     dir_q, dir_d;
    logic                     step_q, step_d;
    logic                     landed_q, landed_d;
    logic                     wave_clear_q, wave_clear_d;
    logic [$clog2(COLS)-1:0]  col_lo_q, col_hi_q, col_lo_e, col_hi_e;
    logic [$clog2(ROWS)-1:0]  row_hi_q, row_hi_e;

    logic [CW-1:0]            period;
    logic [9:0]               y_drop;
    logic signed [12:0]       re, le, be_drop;
    logic                     hit_edge;

    // Extents are frozen at their last valid value once the formation is empty.
    assign col_lo_e = any_alive ? col_lo : col_lo_q;
    assign col_hi_e = any_alive ? col_hi : col_hi_q;
    assign row_hi_e = any_alive ? row_hi : row_hi_q;

    assign period = alive_cnt >> PERIOD_SHIFT;
    assign y_drop = form_y_q + 10'(DROP);

    always_comb begin
        re       = $signed({form_x_q[11], form_x_q}) + 13'(int'(col_hi_e) * PITCH_X)
                   + 13'(ENEMY_W);
        le       = $signed({form_x_q[11], form_x_q}) + 13'(int'(col_lo_e) * PITCH_X);
        be_drop  = $signed({3'b000, y_drop}) + 13'(int'(row_hi_e) * PITCH_Y) + 13'(ENEMY_H);
        hit_edge = dir_q ? ((le - 13'(ENEMY_SPEED)) < 13'sd0)
                         : ((re + 13'(ENEMY_SPEED)) > 13'(HRES));
    end

    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        form_x_d     = form_x_q;
        form_y_d     = form_y_q;
        dir_d        = dir_q;
        landed_d     = landed_q;
        step_d       = 1'b0;
        wave_clear_d = 1'b0;
        if (restart) begin
            state_d  = StMarch;
            fcnt_d   = '0;
            form_x_d = 12'(START_X);
            form_y_d = 10'(START_Y);
            dir_d    = 1'b0;
            landed_d = 1'b0;
        end else if (state_q == StMarch && run) begin
            if (!any_alive) begin
                state_d      = StClear;
                wave_clear_d = 1'b1;
            end else if (frame) begin
                // >= so a shrinking period acts on the very next frame
                if (fcnt_q >= period) begin
                    fcnt_d = '0;
                    step_d = 1'b1;
                    if (hit_edge) begin
                        form_y_d = y_drop;
                        dir_d    = ~dir_q;
                        if (be_drop >= 13'(LAND_Y)) begin
                            state_d  = StLanded;
                            landed_d = 1'b1;
                        end
                    end else if (dir_q) begin
                        form_x_d = form_x_q - 12'(ENEMY_SPEED);
                    end else begin
                        form_x_d = form_x_q + 12'(ENEMY_SPEED);
                    end
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            fcnt_q       <= '0;
            form_x_q     <= 12'(START_X);
            form_y_q     <= 10'(START_Y);
            dir_q        <= 1'b0;
            step_q       <= 1'b0;
            landed_q     <= 1'b0;
            wave_clear_q <= 1'b0;
            col_lo_q     <= '0;
            col_hi_q     <= $clog2(COLS)'(COLS - 1);
            row_hi_q     <= $clog2(ROWS)'(ROWS - 1);
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            form_x_q     <= form_x_d;
            form_y_q     <= form_y_d;
            dir_q        <= dir_d;
            step_q       <= step_d;
            landed_q     <= landed_d;
            wave_clear_q <= wave_clear_d;
            if (any_alive) begin
                col_lo_q <= col_lo;
                col_hi_q <= col_hi;
                row_hi_q <= row_hi;
            end
        end
    end

    assign form_x     = form_x_q;
    assign form_y     = form_y_q;
    assign dir        = dir_q;
    assign step       = step_q;
    assign landed     = landed_q;
    assign wave_clear = wave_clear_q;

endmodule
